cnn_img_feeder: RTL and testbench

Host-side initiator for the CNN inference core (`top_cnn`). It accepts a serial pixel stream and packs 144 8-bit pixels into the 1152-bit `input_img_source` bus. It then issues the start strobe (`valid`) to the core, waits for the core's `ready`, and captures `predict_number`. The result is returned to the host on a valid/ready result channel, with a timeout guard against a hung core.

---
 rtl/cnn_img_feeder.sv | 108 ++++++++++
 tb/tb_cnn_img_feeder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_img_feeder.sv
// Packs a serial pixel stream into a full CNN image, starts the core, and returns its
// prediction over a valid/ready result channel. A timeout aborts the frame if the core hangs.
module cnn_img_feeder #(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 144,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         s_pix,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [NUM_PIX*PIX_W-1:0] cnn_img,
    output logic                     cnn_valid,
    input  logic                     cnn_ready,
    input  logic [31:0]              cnn_predict,
    output logic [31:0]              m_predict,
    output logic                     m_timeout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [15:0]              frame_cnt,
    output logic                     busy
);

    localparam int CW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {FILL, START, WAIT, RESULT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] pix_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          pix_hs;
    logic          last_pix;
    logic          tmo_hit;

    assign pix_hs   = (state == FILL) && s_valid;
    assign last_pix = (pix_cnt == CW'(NUM_PIX - 1));
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));

    assign s_ready  = (state == FILL);
    assign busy     = (state == START) || (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (pix_hs && last_pix) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (cnn_ready || tmo_hit) state_nxt = RESULT;
            RESULT:  if (m_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnn_valid <= 1'b0;
            m_valid   <= 1'b0;
        end else begin
            cnn_valid <= (state_nxt == START);
            m_valid   <= (state_nxt == RESULT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnn_img   <= '0;
            pix_cnt   <= '0;
            tmo_cnt   <= '0;
            m_predict <= '0;
            m_timeout <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (pix_hs) begin
                cnn_img[pix_cnt*PIX_W +: PIX_W] <= s_pix;
                pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            end
            case (state)
                START: tmo_cnt <= '0;
                WAIT: begin
                    // A completion in the same cycle as the timeout still counts as success.
                    if (cnn_ready) begin
                        m_predict <= cnn_predict;
                        m_timeout <= 1'b0;
                    end else if (tmo_hit) begin
                        m_predict <= '0;
                        m_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESULT: if (m_ready) frame_cnt <= frame_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_img_feeder.sv
// Directed bench for cnn_img_feeder with TIMEOUT=16 and a hand-driven core model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cnn_img_feeder;

    localparam int PIX_W   = 8;
    localparam int NUM_PIX = 144;
    localparam int TIMEOUT = 16;
    localparam int IMG_W   = NUM_PIX * PIX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [PIX_W-1:0] s_pix;
    logic             s_valid;
    logic             s_ready;
    logic [IMG_W-1:0] cnn_img;
    logic             cnn_valid;
    logic             cnn_ready;
    logic [31:0]      cnn_predict;
    logic [31:0]      m_predict;
    logic             m_timeout;
    logic             m_valid;
    logic             m_ready;
    logic [15:0]      frame_cnt;
    logic             busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [IMG_W-1:0] exp_img;

    always #5 clk = ~clk;

    cnn_img_feeder #(.PIX_W(PIX_W), .NUM_PIX(NUM_PIX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_pix(s_pix), .s_valid(s_valid), .s_ready(s_ready),
        .cnn_img(cnn_img), .cnn_valid(cnn_valid), .cnn_ready(cnn_ready),
        .cnn_predict(cnn_predict), .m_predict(m_predict), .m_timeout(m_timeout),
        .m_valid(m_valid), .m_ready(m_ready), .frame_cnt(frame_cnt), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives a full frame of pixels base, base+1, ...; returns at the falling edge after the last handshake.
    task automatic send_pixels(input logic [7:0] base, input bit gapped);
        for (int k = 0; k < NUM_PIX; k++) begin
            if (gapped) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_pix   = base + 8'(k);
            exp_img[k*PIX_W +: PIX_W] = base + 8'(k);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_pix = '0; s_valid = 1'b0; cnn_ready = 1'b0; cnn_predict = '0; m_ready = 1'b0;
        exp_img = '0;
        tick();
        tick();
        vec_cnt++;
        if (s_ready !== 1'b1 || cnn_valid !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: s_ready=%b cnn_valid=%b m_valid=%b busy=%b, want 1 0 0 0",
                     s_ready, cnn_valid, m_valid, busy);
        end
        vec_cnt++;
        if (m_predict !== 32'd0 || m_timeout !== 1'b0 || frame_cnt !== 16'd0 || cnn_img !== '0) begin
            err_cnt++;
            $display("FAIL reset_data: m_predict=%0h m_timeout=%b frame_cnt=%0h img_lo=%0h, want all 0",
                     m_predict, m_timeout, frame_cnt, cnn_img[31:0]);
        end
        rst = 1'b0;
        tick();
        vec_cnt++;
        if (s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_release: s_ready=%b want 1", s_ready);
        end
    endtask

    task automatic test_single_frame();
        send_pixels(8'h00, 1'b0);
        vec_cnt++;
        if (cnn_valid !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_start: cnn_valid=%b busy=%b s_ready=%b, want 1 1 0", cnn_valid, busy, s_ready);
        end
        vec_cnt++;
        if (cnn_img[7:0] !== 8'h00 || cnn_img[1151:1144] !== 8'h8F || cnn_img !== exp_img) begin
            err_cnt++;
            $display("FAIL single_img: first=%0h last=%0h, want 00 8f and full image match",
                     cnn_img[7:0], cnn_img[1151:1144]);
        end
        tick();
        vec_cnt++;
        if (cnn_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_pulse: cnn_valid=%b want 0 one cycle later", cnn_valid);
        end
        for (int i = 2; i <= 10; i++) begin
            vec_cnt++;
            if (m_valid !== 1'b0 || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL single_wait: cycle %0d m_valid=%b busy=%b, want 0 1", i - 1, m_valid, busy);
            end
            tick();
        end
        cnn_ready = 1'b1; cnn_predict = 32'd7;
        tick();
        cnn_ready = 1'b0; cnn_predict = 32'd0;
        vec_cnt++;
        if (m_valid !== 1'b1 || m_predict !== 32'd7 || m_timeout !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_result: m_valid=%b m_predict=%0d m_timeout=%b busy=%b, want 1 7 0 0",
                     m_valid, m_predict, m_timeout, busy);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        vec_cnt++;
        if (frame_cnt !== 16'd1 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_done: frame_cnt=%0d m_valid=%b s_ready=%b, want 1 0 1", frame_cnt, m_valid, s_ready);
        end
    endtask

    task automatic test_gapped_backpressure();
        send_pixels(8'h00, 1'b1);
        vec_cnt++;
        if (cnn_valid !== 1'b1 || cnn_img !== exp_img) begin
            err_cnt++;
            $display("FAIL gap_img: cnn_valid=%b first=%0h last=%0h, want 1 and image 00..8f",
                     cnn_valid, cnn_img[7:0], cnn_img[1151:1144]);
        end
        tick();
        tick();
        cnn_ready = 1'b1; cnn_predict = 32'h55;
        tick();
        cnn_ready = 1'b0; cnn_predict = 32'd0;
        for (int i = 0; i < 20; i++) begin
            vec_cnt++;
            if (m_valid !== 1'b1 || m_predict !== 32'h55 || m_timeout !== 1'b0 || s_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL gap_hold: cycle %0d m_valid=%b m_predict=%0h m_timeout=%b s_ready=%b, want 1 55 0 0",
                         i, m_valid, m_predict, m_timeout, s_ready);
            end
            // stray core completion and pixels during RESULT must be ignored
            cnn_ready = (i == 5); cnn_predict = 32'h99;
            s_valid = (i == 8); s_pix = 8'hEE;
            tick();
        end
        cnn_ready = 1'b0; s_valid = 1'b0;
        vec_cnt++;
        if (cnn_img !== exp_img) begin
            err_cnt++;
            $display("FAIL gap_img_hold: img_lo=%0h want image unchanged", cnn_img[31:0]);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        vec_cnt++;
        if (frame_cnt !== 16'd2 || s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL gap_done: frame_cnt=%0d s_ready=%b, want 2 1", frame_cnt, s_ready);
        end
    endtask

    task automatic test_timeout();
        send_pixels(8'h20, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            vec_cnt++;
            if (m_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL tmo_early: m_valid=%b at %0d cycles after cnn_valid, want 0", m_valid, i);
            end
        end
        tick();
        vec_cnt++;
        if (m_valid !== 1'b1 || m_timeout !== 1'b1 || m_predict !== 32'd0) begin
            err_cnt++;
            $display("FAIL tmo_result: m_valid=%b m_timeout=%b m_predict=%0h, want 1 1 0", m_valid, m_timeout, m_predict);
        end
        cnn_ready = 1'b1; cnn_predict = 32'hAA;
        tick();
        cnn_ready = 1'b0;
        vec_cnt++;
        if (m_predict !== 32'd0 || m_timeout !== 1'b1) begin
            err_cnt++;
            $display("FAIL tmo_late: m_predict=%0h m_timeout=%b, want 0 1", m_predict, m_timeout);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        cnn_ready = 1'b1;
        tick();
        cnn_ready = 1'b0; cnn_predict = 32'd0;
        vec_cnt++;
        if (frame_cnt !== 16'd3 || busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL tmo_done: frame_cnt=%0d busy=%b m_valid=%b s_ready=%b, want 3 0 0 1",
                     frame_cnt, busy, m_valid, s_ready);
        end
    endtask

    task automatic test_collision();
        send_pixels(8'h40, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) tick();
        cnn_ready = 1'b1; cnn_predict = 32'd3;
        tick();
        cnn_ready = 1'b0; cnn_predict = 32'd0;
        vec_cnt++;
        if (m_valid !== 1'b1 || m_predict !== 32'd3 || m_timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL collision: m_valid=%b m_predict=%0d m_timeout=%b, want 1 3 0", m_valid, m_predict, m_timeout);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        m_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_pixels(8'h60 + 8'(f * 8'h30), 1'b0);
            vec_cnt++;
            if (cnn_valid !== 1'b1 || cnn_img !== exp_img) begin
                err_cnt++;
                $display("FAIL b2b_img: frame %0d cnn_valid=%b first=%0h last=%0h, want 1 %0h %0h",
                         f, cnn_valid, cnn_img[7:0], cnn_img[1151:1144], exp_img[7:0], exp_img[1151:1144]);
            end
            tick();
            cnn_ready = 1'b1; cnn_predict = 32'(100 + f);
            tick();
            cnn_ready = 1'b0;
            vec_cnt++;
            if (m_valid !== 1'b1 || m_predict !== 32'(100 + f)) begin
                err_cnt++;
                $display("FAIL b2b_result: frame %0d m_valid=%b m_predict=%0d, want 1 %0d", f, m_valid, m_predict, 100 + f);
            end
            tick();
            vec_cnt++;
            if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_cnt !== 16'(f)) begin
                err_cnt++;
                $display("FAIL b2b_cnt: frame %0d s_ready=%b m_valid=%b frame_cnt=%0h, want 1 0 %0h",
                         f, s_ready, m_valid, frame_cnt, f);
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 50; k++) begin
            s_valid = 1'b1; s_pix = 8'hC0 + 8'(k);
            tick();
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if (s_ready !== 1'b1 || cnn_valid !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 ||
            m_predict !== 32'd0 || m_timeout !== 1'b0 || frame_cnt !== 16'd0 || cnn_img !== '0) begin
            err_cnt++;
            $display("FAIL async_reset: s_ready=%b cnn_valid=%b m_valid=%b busy=%b m_predict=%0h frame_cnt=%0h img_lo=%0h",
                     s_ready, cnn_valid, m_valid, busy, m_predict, frame_cnt, cnn_img[31:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vec_cnt++;
        if (s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL async_release: s_ready=%b want 1", s_ready);
        end
        send_pixels(8'h80, 1'b0);
        vec_cnt++;
        if (cnn_valid !== 1'b1 || cnn_img !== exp_img) begin
            err_cnt++;
            $display("FAIL async_refill: cnn_valid=%b first=%0h last=%0h, want 1 80 0f",
                     cnn_valid, cnn_img[7:0], cnn_img[1151:1144]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gapped_backpressure();
        test_timeout();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
